// File: rtl/hcsr04_pkg.sv
// Shared defaults and state type for the HC-SR04 distance filter.
package hcsr04_pkg;

  localparam int DIST_W_DEF     = 12;
  localparam int MIN_MM_DEF     = 20;
  localparam int MAX_MM_DEF     = 4000;
  localparam int MAX_REJECT_DEF = 3;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/hcsr04_median3.sv
// Registered median-of-3 selector; output holds while en is low.
module hcsr04_median3 #(
  parameter int DIST_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  output logic [DIST_W-1:0] med
);

  function automatic logic [DIST_W-1:0] median3(input logic [DIST_W-1:0] x,
                                                input logic [DIST_W-1:0] y,
                                                input logic [DIST_W-1:0] z);
    if (x >= y) return (y >= z) ? y : ((x >= z) ? z : x);
    else        return (x >= z) ? x : ((y >= z) ? z : y);
  endfunction

  always_ff @(posedge clk) begin
    if (en) med <= median3(a, b, c);
  end

endmodule

// File: rtl/hcsr04_dist_filter.sv
// Range-gated, median-of-3 filtered distance with proximity alarm and reject fault.
module hcsr04_dist_filter
  import hcsr04_pkg::*;
#(
  parameter int DIST_W     = DIST_W_DEF,
  parameter int MIN_MM     = MIN_MM_DEF,
  parameter int MAX_MM     = MAX_MM_DEF,
  parameter int MAX_REJECT = MAX_REJECT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_val,
  input  logic [DIST_W-1:0] thr_near,
  input  logic [DIST_W-1:0] thr_hyst,
  output logic [DIST_W-1:0] dist_out,
  output logic              dist_out_val,
  output logic              near,
  output logic              fault,
  output logic [1:0]        rej_cnt
);

  state_t            state, state_next;
  logic [1:0]        fill;
  logic [DIST_W-1:0] w0, w1, w2;
  logic              accept, reject, emit;
  logic [1:0]        rej_inc;
  logic              vld_p0;
  logic [DIST_W-1:0] med_p0;
  logic [DIST_W-1:0] rel_thr;

  function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] x,
                                                input logic [DIST_W-1:0] y);
    logic [DIST_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[DIST_W] ? '1 : s[DIST_W-1:0];
  endfunction

  assign accept  = dist_val && (dist_in >= DIST_W'(MIN_MM)) && (dist_in <= DIST_W'(MAX_MM));
  assign reject  = dist_val && !accept;
  assign rej_inc = (rej_cnt == 2'(MAX_REJECT)) ? rej_cnt : rej_cnt + 2'd1;
  assign rel_thr = sat_add(thr_near, thr_hyst);

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    fault      = 1'b0;
    case (state)
      WARM: begin
        if (accept && fill == 2'd2) begin
          state_next = RUN;
          emit       = 1'b1;
        end else if (reject && rej_inc == 2'(MAX_REJECT)) begin
          state_next = FAULT;
        end
      end
      RUN: begin
        emit = accept;
        if (reject && rej_inc == 2'(MAX_REJECT)) state_next = FAULT;
      end
      FAULT: begin
        fault = 1'b1;
        if (accept) state_next = WARM;
      end
      default: state_next = WARM;
    endcase
  end

  // Stage p0: window shift and median register, both on the accept edge
  hcsr04_median3 #(.DIST_W(DIST_W)) u_median3 (
    .clk (clk),
    .en  (emit),
    .a   (dist_in),
    .b   (w0),
    .c   (w1),
    .med (med_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WARM;
      fill    <= 2'd0;
      rej_cnt <= 2'd0;
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      vld_p0  <= 1'b0;
    end else begin
      state  <= state_next;
      vld_p0 <= emit;
      if (state_next == FAULT) begin
        fill <= 2'd0;
        w0   <= '0;
        w1   <= '0;
        w2   <= '0;
        if (reject) rej_cnt <= rej_inc;
      end else if (accept) begin
        w0      <= dist_in;
        w1      <= w0;
        w2      <= w1;
        rej_cnt <= 2'd0;
        if (fill != 2'd3) fill <= fill + 2'd1;
      end else if (reject) begin
        rej_cnt <= rej_inc;
      end
    end
  end

  // Stage p1: output register and alarm; an in-flight result is dropped on fault entry
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_out     <= '0;
      dist_out_val <= 1'b0;
      near         <= 1'b0;
    end else begin
      dist_out_val <= vld_p0 && (state_next != FAULT);
      if (state_next == FAULT) begin
        near <= 1'b0;
      end else if (vld_p0) begin
        dist_out <= med_p0;
        if (med_p0 < thr_near)      near <= 1'b1;
        else if (med_p0 >= rel_thr) near <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hcsr04_dist_filter.md
HCSR04_DIST_FILTER -- requirements
Module: hcsr04_dist_filter

Interface
REQ-001 Parameter DIST_W, 12: distance width in mm, equal to the sensor controller distance output.
REQ-002 Parameter MIN_MM, 20: smallest accepted distance in mm.
REQ-003 Parameter MAX_MM, 4000: largest accepted distance in mm.
REQ-004 Parameter MAX_REJECT, 3: consecutive rejected samples that enter FAULT.
REQ-005 Port clk  in  1: single clock for all logic.
REQ-006 Port rst  in  1: synchronous, active-high reset.
REQ-007 Port dist_in  in  DIST_W: raw distance from the HC-SR04 controller.
REQ-008 Port dist_val  in  1: one-cycle strobe marking dist_in valid.
REQ-009 Port thr_near  in  DIST_W: proximity alarm set threshold in mm.
REQ-010 Port thr_hyst  in  DIST_W: alarm release hysteresis in mm.
REQ-011 Port dist_out  out  DIST_W: median-of-3 filtered distance.
REQ-012 Port dist_out_val  out  1: one-cycle strobe marking dist_out valid.
REQ-013 Port near  out  1: proximity alarm level.
REQ-014 Port fault  out  1: level, high while in FAULT.
REQ-015 Port rej_cnt  out  2: current consecutive-reject count, saturating at MAX_REJECT.

Function
REQ-016 A sample is accepted when dist_val=1 and MIN_MM <= dist_in <= MAX_MM, and rejected otherwise.
REQ-017 An accepted sample shifts into a 3-entry window (newest in, oldest out), increments fill (saturating at 3), and clears rej_cnt.
REQ-018 A rejected sample leaves the window unchanged, increments rej_cnt (saturating), and produces no output strobe.
REQ-019 The FSM has three states: WARM (fill<3), RUN (fill=3) and FAULT.
REQ-020 WARM->RUN occurs on the accept that makes fill=3; RUN and WARM go ->FAULT on the reject that makes rej_cnt=MAX_REJECT.
REQ-021 In FAULT, the window and fill are cleared, fault=1, near is held at 0, and no strobes are issued.
REQ-022 FAULT->WARM occurs on the next accepted sample, which becomes window entry 1 (fill=1), with fault=0 and rej_cnt=0.
REQ-023 In RUN, each accepted sample produces dist_out=median(window) with dist_out_val high exactly 2 cycles after the dist_val cycle.
REQ-024 No output is produced in WARM.
REQ-025 The pipeline accepts dist_val on back-to-back cycles, giving one output strobe per accepted RUN sample in order.
REQ-026 The median uses unsigned compare; on equal values any equal element is the result.
REQ-027 near is set when a strobed dist_out < thr_near.
REQ-028 near is cleared when a strobed dist_out >= thr_near + thr_hyst, with the sum computed in DIST_W+1 bits and saturated to 2^DIST_W-1.
REQ-029 near holds its value between strobes.
REQ-030 near updates in the same cycle as dist_out_val.
REQ-031 dist_out holds its last value between strobes.
REQ-032 thr_near and thr_hyst are sampled combinationally at the update cycle; changing them does not itself toggle near.

Reset
REQ-033 While rst=1 at a clk edge: state=WARM, fill=0, window=0, rej_cnt=0, dist_out=0, dist_out_val=0, near=0, fault=0.
REQ-034 Reset mid-operation discards in-flight pipeline samples, and no strobe appears in the cycles after reset deassertion.
REQ-035 dist_val asserted in the same cycle as rst is ignored.

Structure
REQ-036 Package hcsr04_pkg holds DIST_W, MIN_MM, MAX_MM, MAX_REJECT defaults and the state enum type (WARM, RUN, FAULT).
REQ-037 Sub-module hcsr04_median3 implements a registered 3-input median sorter (1 cycle), instantiated once.
REQ-038 Everything else (window, FSM, alarm, counters) resides in hcsr04_dist_filter.

Verification
REQ-039 After reset, strobe 100,110,105,120 (thr_near=50, thr_hyst=10) -> outputs only on the 3rd sample (105, latency 2) and 4th sample (110); near=0.
REQ-040 In RUN, strobe samples 10, 5000, 10 -> each is rejected; rej_cnt goes 1,2,3; fault=1 after the 3rd; window is cleared.
REQ-041 From FAULT, strobe 200,200,200 -> fault=0 on the first; output 200 on the 3rd only.
REQ-042 Hysteresis with thr_near=100, thr_hyst=20: medians 90->near=1; 115->near stays 1; 120->near=0; 99->near=1.
REQ-043 dist_val on 4 consecutive cycles in RUN -> 4 consecutive dist_out_val strobes, each with the correct median.
REQ-044 With thr_near=4090, thr_hyst=100 -> the release threshold saturates at 4095; near stays 1 for 4000.
REQ-045 Assert rst for 1 cycle one cycle after dist_val in RUN -> no strobe follows, and all outputs are 0.
